// File: rtl/lpf_meas_pkg.sv
// Shared types and constants for the LPF measurement blocks (peak meter and
// future crossing/frequency meters).
package lpf_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } meter_state_t;

  localparam real GAIN_FLOOR_DB = -100.0;

  // Gain of a measured peak against a reference peak, floored when undefined.
  function automatic real gain_db(input real vpk, input real vref);
    if (vpk > 0.0 && vref > 0.0) return 20.0 * $log10(vpk / vref);
    return GAIN_FLOOR_DB;
  endfunction

endpackage

// File: rtl/lpf_xing_det.sv
// Combinational hysteresis comparator: flags a sample clearly above or clearly
// below the reference level; samples inside the band raise neither flag.
module lpf_xing_det #(
  parameter real HYST = 0.01
) (
  input  real  i_sample_in,
  input  real  i_vdc_ref,
  output logic o_above,
  output logic o_below
);

  assign o_above = i_sample_in > (i_vdc_ref + HYST);
  assign o_below = i_sample_in < (i_vdc_ref - HYST);

endmodule

// File: rtl/lpf_peak_meter.sv
// Peak/period meter for the dms_lpf2 output; optional gain output enabled by
// defining LPF_PEAK_METER_GAIN_DB_EN.
//   state | meaning
//   IDLE  | disabled, trackers cleared, outputs hold
//   ACQ   | enabled, waiting for the first excursion out of the band
//   HIGH  | sample last seen above band, tracking vhi
//   LOW   | sample last seen below band, tracking vlo
module lpf_peak_meter
  import lpf_meas_pkg::*;
#(
  parameter real              HYST    = 0.01,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] MAX_CYC = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              sample_in,
  input  real              vdc_ref,
  input  real              vpk_ref,
  output real              vpk_out,
  output logic [CNT_W-1:0] period_cyc,
  output logic             meas_valid,
  output logic             no_signal,
  output logic [1:0]       state_o
`ifdef LPF_PEAK_METER_GAIN_DB_EN
  ,
  output real              meas_gain_db
`endif
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meter_state_t     r_state;
  real              r_vhi;
  real              r_vlo;
  real              r_vpk_out;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_meas_valid;
  logic             r_no_signal;
  logic             r_seen_low;
  logic             r_have_up;

  logic             w_above;
  logic             w_below;
  logic             w_up_xing;
  logic             w_meas;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;
  real              w_vpk_new;

  lpf_xing_det #(
    .HYST (HYST)
  ) u_xing_det (
    .i_sample_in (sample_in),
    .i_vdc_ref   (vdc_ref),
    .o_above     (w_above),
    .o_below     (w_below)
  );

  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;
  assign w_up_xing = (r_state == LOW) && w_above;
  // Only an upward crossing preceded by another one closes a full cycle.
  assign w_meas    = en && w_up_xing && r_seen_low && r_have_up;
  assign w_timeout = (r_state != IDLE) && (r_cnt == MAX_CYC) && !w_up_xing;
  assign w_vpk_new = (r_vhi - r_vlo) / 2.0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vhi        <= 0.0;
      r_vlo        <= 0.0;
      r_cnt        <= '0;
      r_seen_low   <= 1'b0;
      r_have_up    <= 1'b0;
      r_vpk_out    <= 0.0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_no_signal  <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!en) begin
        r_state    <= IDLE;
        r_vhi      <= 0.0;
        r_vlo      <= 0.0;
        r_cnt      <= '0;
        r_seen_low <= 1'b0;
        r_have_up  <= 1'b0;
      end else if (w_timeout) begin
        r_state     <= ACQ;
        r_vhi       <= 0.0;
        r_vlo       <= 0.0;
        r_cnt       <= '0;
        r_seen_low  <= 1'b0;
        r_have_up   <= 1'b0;
        r_no_signal <= 1'b1;
        r_vpk_out   <= 0.0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ACQ;
            r_cnt   <= '0;
          end
          ACQ: begin
            r_cnt <= w_cnt_inc;
            if (w_above) begin
              r_state <= HIGH;
              r_vhi   <= sample_in;
            end else if (w_below) begin
              r_state    <= LOW;
              r_vlo      <= sample_in;
              r_seen_low <= 1'b1;
            end
          end
          HIGH: begin
            r_cnt <= w_cnt_inc;
            if (w_below) begin
              r_state    <= LOW;
              r_vlo      <= sample_in;
              r_seen_low <= 1'b1;
            end else if (sample_in > r_vhi) begin
              r_vhi <= sample_in;
            end
          end
          LOW: begin
            if (w_above) begin
              r_state   <= HIGH;
              r_vhi     <= sample_in;
              r_have_up <= 1'b1;
              r_cnt     <= CNT_ONE;
              if (w_meas) begin
                r_vpk_out    <= w_vpk_new;
                r_period     <= r_cnt;
                r_meas_valid <= 1'b1;
                r_no_signal  <= 1'b0;
              end
            end else begin
              r_cnt <= w_cnt_inc;
              if (sample_in < r_vlo) r_vlo <= sample_in;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign vpk_out    = r_vpk_out;
  assign period_cyc = r_period;
  assign meas_valid = r_meas_valid;
  assign no_signal  = r_no_signal;
  assign state_o    = r_state;

`ifdef LPF_PEAK_METER_GAIN_DB_EN
  real r_gain_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain_db <= GAIN_FLOOR_DB;
    end else if (en && w_timeout) begin
      r_gain_db <= GAIN_FLOOR_DB;
    end else if (w_meas) begin
      r_gain_db <= gain_db(w_vpk_new, vpk_ref);
    end
  end

  assign meas_gain_db = r_gain_db;
`else
  real w_unused_vpk_ref;
  assign w_unused_vpk_ref = vpk_ref;
`endif

endmodule

// File: tb/tb_lpf_peak_meter.sv
// Randomized bench for lpf_peak_meter against a timestamp-based reference model.
module tb_lpf_peak_meter;

  localparam real H      = 0.01;
  localparam int  TB_MAX = 200;
  localparam real PI     = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  real         sample_in;
  real         vdc_ref;
  real         vpk_ref;
  real         vpk_out;
  logic [15:0] period_cyc;
  logic        meas_valid;
  logic        no_signal;
  logic [1:0]  state_o;
`ifdef LPF_PEAK_METER_GAIN_DB_EN
  real         meas_gain_db;
`endif

  lpf_peak_meter #(
    .HYST    (H),
    .CNT_W   (16),
    .MAX_CYC (16'd200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sample_in  (sample_in),
    .vdc_ref    (vdc_ref),
    .vpk_ref    (vpk_ref),
    .vpk_out    (vpk_out),
    .period_cyc (period_cyc),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .state_o    (state_o)
`ifdef LPF_PEAK_METER_GAIN_DB_EN
    ,
    .meas_gain_db (meas_gain_db)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input real obs, input real exp, input real tol);
    n_chk++;
    if (obs >= exp - tol && obs <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0f, want %0f (tol %0g) at %0t", tag, obs, exp, tol, $time);
  endtask

  // Reference model: tracks which side of the band the signal is on and the
  // timestamp of the last upward crossing; period = now - last crossing.
  bit  m_active  = 0;
  int  m_side    = 0;
  int  m_ref     = 0;
  bit  m_have_up = 0;
  real m_hi      = 0.0;
  real m_lo      = 0.0;
  real e_vpk     = 0.0;
  int  e_per     = 0;
  bit  e_valid   = 0;
  bit  e_ns      = 0;
  real e_gain    = -100.0;

  function automatic int exp_state();
    if (!m_active)  return 0;
    if (m_side == 0) return 1;
    if (m_side > 0)  return 2;
    return 3;
  endfunction

  task automatic model_step(input int t, input bit r, input bit e, input real s,
                            input real vdc, input real vref);
    bit up;
    e_valid = 0;
    if (r) begin
      m_active = 0; m_side = 0; m_have_up = 0;
      e_vpk = 0.0; e_per = 0; e_ns = 0; e_gain = -100.0;
    end else if (!e) begin
      m_active = 0; m_side = 0; m_have_up = 0;
    end else if (!m_active) begin
      m_active = 1; m_side = 0; m_ref = t + 1;
    end else begin
      up = (m_side < 0) && (s > vdc + H);
      if (!up && (t - m_ref) == TB_MAX) begin
        e_ns = 1; e_vpk = 0.0; e_gain = -100.0;
        m_side = 0; m_have_up = 0; m_ref = t + 1;
      end else if (up) begin
        if (m_have_up) begin
          e_vpk   = (m_hi - m_lo) / 2.0;
          e_per   = t - m_ref;
          e_valid = 1;
          e_ns    = 0;
          e_gain  = (e_vpk > 0.0 && vref > 0.0) ? 20.0 * $log10(e_vpk / vref) : -100.0;
        end
        m_have_up = 1; m_ref = t; m_side = 1; m_hi = s;
      end else if (m_side == 0) begin
        if (s > vdc + H) begin m_side = 1; m_hi = s; end
        else if (s < vdc - H) begin m_side = -1; m_lo = s; end
      end else if (m_side > 0) begin
        if (s < vdc - H) begin m_side = -1; m_lo = s; end
        else if (s > m_hi) m_hi = s;
      end else begin
        if (s < m_lo) m_lo = s;
      end
    end
  endtask

  int  g_cyc = 0;
  bit  g_rst, g_en;
  int  g_mode;
  real g_amp, g_off, g_ph, g_vdc, g_vref;
  int  g_per;
  int  ph_start, n_valid, first_valid, first_ns;

  function automatic real noise();
    return real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
  endfunction

  function automatic real gen(input int c);
    real sn;
    sn = g_off + g_amp * $sin(2.0 * PI * real'(c) / real'(g_per) + g_ph);
    case (g_mode)
      0:       return sn;
      1:       return g_off + g_amp * noise();
      2:       return g_off;
      default: return sn + 0.05 * g_amp * noise();
    endcase
  endfunction

  task automatic start_phase();
    ph_start = g_cyc; n_valid = 0; first_valid = -1; first_ns = -1;
  endtask

  task automatic step();
    real s;
    @(negedge clk);
    chk("state", real'(state_o), real'(exp_state()), 0.0);
    chk("valid", real'(meas_valid), real'(e_valid), 0.0);
    chk("nosig", real'(no_signal), real'(e_ns), 0.0);
    chk("period", real'(period_cyc), real'(e_per), 0.0);
    chk("vpk", vpk_out, e_vpk, 1e-9);
`ifdef LPF_PEAK_METER_GAIN_DB_EN
    chk("gain", meas_gain_db, e_gain, 1e-9);
`endif
    if (meas_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = g_cyc - ph_start;
    end
    if (no_signal && first_ns < 0) first_ns = g_cyc - ph_start;
    s = gen(g_cyc);
    rst = g_rst; en = g_en; sample_in = s; vdc_ref = g_vdc; vpk_ref = g_vref;
    model_step(g_cyc, g_rst, g_en, s, g_vdc, g_vref);
    g_cyc++;
  endtask

  initial begin
    g_rst = 1; g_en = 0; g_mode = 0; g_amp = 1.0; g_off = 0.0; g_per = 100;
    g_ph = 0.0; g_vdc = 0.0; g_vref = 1.0;
    rst = 1; en = 0; sample_in = 0.0; vdc_ref = 0.0; vpk_ref = 1.0;
    start_phase();
    repeat (3) step();
    chk("rst_vpk", vpk_out, 0.0, 0.0);
    chk("rst_period", real'(period_cyc), 0.0, 0.0);
    chk("rst_state", real'(state_o), 0.0, 0.0);

    // 1 MHz unit sine around 0
    g_rst = 0; g_en = 1; g_ph = real'($urandom_range(0, 628)) / 100.0;
    start_phase();
    repeat (400) step();
    chk("s1_first_mv", real'(first_valid >= 95 && first_valid <= 210), 1.0, 0.0);
    chk("s1_period", real'(period_cyc), 100.0, 1.0);
    chk("s1_vpk", vpk_out, 1.0, 0.002);

    // reset mid-measurement
    repeat (150) step();
    g_rst = 1; step(); g_rst = 0;
    #6;
    chk("rmid_vpk", vpk_out, 0.0, 0.0);
    chk("rmid_period", real'(period_cyc), 0.0, 0.0);
    chk("rmid_valid", real'(meas_valid), 0.0, 0.0);
    chk("rmid_state", real'(state_o), 0.0, 0.0);
    start_phase();
    repeat (400) step();
    chk("rmid_first_mv", real'(first_valid >= 95 && first_valid <= 210), 1.0, 0.0);
    chk("rmid_period2", real'(period_cyc), 100.0, 1.0);

    // enable dropped for 50 cycles
    repeat (250) step();
    g_en = 0; step(); start_phase();
    repeat (49) step();
    #6;
    chk("en_idle", real'(state_o), 0.0, 0.0);
    chk("en_no_mv", real'(n_valid + int'(meas_valid)), 0.0, 0.0);
    chk("en_hold_vpk", vpk_out, 1.0, 0.002);
    chk("en_hold_per", real'(period_cyc), 100.0, 1.0);
    g_en = 1; start_phase();
    repeat (300) step();
    chk("en_resume_mv", real'(n_valid > 0), 1.0, 0.0);
    chk("en_resume_per", real'(period_cyc), 100.0, 1.0);

    // constant inside band -> timeout, then sine clears no_signal
    g_rst = 1; step(); g_rst = 0;
    g_mode = 2; g_off = 0.005; start_phase();
    repeat (450) step();
    chk("to_at", real'(first_ns >= 199 && first_ns <= 205), 1.0, 0.0);
    chk("to_no_mv", real'(n_valid), 0.0, 0.0);
    chk("to_vpk", vpk_out, 0.0, 0.0);
    chk("to_flag", real'(no_signal), 1.0, 0.0);
    g_mode = 0; g_off = 0.0; g_amp = 1.0; start_phase();
    repeat (400) step();
    chk("to_clear", real'(no_signal), 0.0, 0.0);
    chk("to_mv_after", real'(n_valid > 0), 1.0, 0.0);

    // offset stimulus around vdc_ref = 1.0
    g_vdc = 1.0; g_off = 1.0; g_amp = 0.5; g_vref = 1.0; start_phase();
    repeat (400) step();
    chk("off_vpk", vpk_out, 0.5, 0.002);
    chk("off_period", real'(period_cyc), 100.0, 1.0);
`ifdef LPF_PEAK_METER_GAIN_DB_EN
    chk("gain_6db", meas_gain_db, -6.02, 0.05);
    g_vref = 0.0;
    repeat (250) step();
    chk("gain_floor", meas_gain_db, -100.0, 0.0);
`endif

    // randomized blocks
    for (int b = 0; b < 40; b++) begin
      g_mode = int'($urandom_range(0, 3));
      g_per  = int'($urandom_range(20, 180));
      g_amp  = real'($urandom_range(2, 100)) / 100.0;
      g_vdc  = real'(int'($urandom_range(0, 100)) - 50) / 100.0;
      g_off  = (g_mode == 2) ? g_vdc + real'(int'($urandom_range(0, 40)) - 20) / 1000.0 : g_vdc;
      g_ph   = real'($urandom_range(0, 628)) / 100.0;
      g_vref = ($urandom_range(0, 3) == 0) ? 0.0 : real'($urandom_range(10, 100)) / 100.0;
      g_en   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) begin
        g_rst = 1; step(); g_rst = 0;
      end
      repeat (100) step();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
